gd_conv_controller: RTL and testbench

Sequences convergence checking for the 4D gradient-descent engine. Accepts one parameter update per iteration as an old/new Q24.8 coordinate vector. Checks each dimension in turn on a single shared diff-window comparator. Declares convergence after STABLE_CNT consecutive all-dimension-converged iterations, or terminates at MAX_ITER.

---
 rtl/gd_conv_controller.sv | 167 ++++++++++++++++
 tb/tb_gd_conv_controller.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gd_conv_controller.sv
// Convergence sequencer for the gradient-descent engine.
// Each accepted update is checked one dimension per cycle on a single shared
// window comparator; the run ends on sustained convergence or the iteration limit.
//
//   state      | meaning
//   -----------+----------------------------------------------------------
//   S_IDLE     | no run active, waiting for start
//   S_WAIT_UPD | upd_ready high, waiting for the next update vector
//   S_CHECK    | comparing dimension dim_q of the captured vectors
//   S_DECIDE   | update iteration/stable counters, choose next step
//   S_DONE     | one-cycle done pulse, results held
module gd_conv_controller #(
  parameter int N_DIM      = 4,
  parameter int MAX_ITER   = 1000,
  parameter int STABLE_CNT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 upd_valid,
  output logic                 upd_ready,
  input  logic [32*N_DIM-1:0]  x_old,
  input  logic [32*N_DIM-1:0]  x_new,
  output logic                 busy,
  output logic                 done,
  output logic                 converged,
  output logic                 max_iter_hit,
  output logic [15:0]          iter_count,
  output logic [N_DIM-1:0]     conv_mask
);

  localparam int DW = (N_DIM > 1) ? $clog2(N_DIM) : 1;
  localparam logic [15:0]   MAX_ITER_W   = 16'(MAX_ITER);
  localparam logic [3:0]    STABLE_CNT_W = 4'(STABLE_CNT);
  localparam logic [DW-1:0] DIM_LAST     = DW'(N_DIM - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_UPD,
    S_CHECK,
    S_DECIDE,
    S_DONE
  } state_t;

  state_t            state_q;
  logic [31:0]       old_q [N_DIM];
  logic [31:0]       new_q [N_DIM];
  logic [DW-1:0]     dim_q;
  logic              all_conv_q;
  logic [3:0]        stable_q;
  logic [15:0]       iter_q;
  logic [N_DIM-1:0]  mask_q;
  logic              ready_q;
  logic              busy_q;
  logic              done_q;
  logic              conv_q;
  logic              maxh_q;

  logic [31:0]       diff;
  logic              dim_conv;
  logic [15:0]       iter_d;
  logic [3:0]        stable_d;

  // Shared comparator: wrap-around difference of the selected dimension,
  // converged only strictly inside the +/-16 LSB window.
  always_comb begin
    diff     = new_q[dim_q] - old_q[dim_q];
    dim_conv = ($signed(diff) > -32'sd16) && ($signed(diff) < 32'sd16);
  end

  // Counter values that DECIDE commits; the stable count clears on any miss.
  always_comb begin
    iter_d   = iter_q + 16'd1;
    stable_d = all_conv_q ? (stable_q + 4'd1) : 4'd0;
  end

  // Sequencer with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      for (int i = 0; i < N_DIM; i++) begin
        old_q[i] <= '0;
        new_q[i] <= '0;
      end
      dim_q      <= '0;
      all_conv_q <= 1'b0;
      stable_q   <= '0;
      iter_q     <= '0;
      mask_q     <= '0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      conv_q     <= 1'b0;
      maxh_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            conv_q   <= 1'b0;
            maxh_q   <= 1'b0;
            iter_q   <= '0;
            stable_q <= '0;
            mask_q   <= '0;
            busy_q   <= 1'b1;
            ready_q  <= 1'b1;
            state_q  <= S_WAIT_UPD;
          end
        end
        S_WAIT_UPD: begin
          if (upd_valid) begin
            for (int i = 0; i < N_DIM; i++) begin
              old_q[i] <= x_old[32*i +: 32];
              new_q[i] <= x_new[32*i +: 32];
            end
            dim_q      <= '0;
            all_conv_q <= 1'b1;
            ready_q    <= 1'b0;
            state_q    <= S_CHECK;
          end
        end
        S_CHECK: begin
          mask_q[dim_q] <= dim_conv;
          all_conv_q    <= all_conv_q & dim_conv;
          if (dim_q == DIM_LAST) begin
            state_q <= S_DECIDE;
          end else begin
            dim_q <= dim_q + DW'(1);
          end
        end
        S_DECIDE: begin
          iter_q   <= iter_d;
          stable_q <= stable_d;
          // Convergence is tested first so it wins a tie with the limit.
          if (stable_d == STABLE_CNT_W) begin
            conv_q  <= 1'b1;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else if (iter_d == MAX_ITER_W) begin
            maxh_q  <= 1'b1;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            ready_q <= 1'b1;
            state_q <= S_WAIT_UPD;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign upd_ready    = ready_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign converged    = conv_q;
  assign max_iter_hit = maxh_q;
  assign iter_count   = iter_q;
  assign conv_mask    = mask_q;

endmodule

// File: tb/tb_gd_conv_controller.sv
// Scoreboard bench for gd_conv_controller: two instances (limit 3 and limit 2),
// expected per-iteration results queued at issue, checked by a negedge monitor.
module tb_gd_conv_controller;

  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic           start_a, start_b, valid_a, valid_b;
  logic [32*N-1:0] x_old, x_new;

  logic           rdy_a, busy_a, done_a, conv_a, maxh_a;
  logic [15:0]    iter_a;
  logic [N-1:0]   mask_a;
  logic           rdy_b, busy_b, done_b, conv_b, maxh_b;
  logic [15:0]    iter_b;
  logic [N-1:0]   mask_b;

  gd_conv_controller #(.N_DIM(N), .MAX_ITER(3), .STABLE_CNT(2)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .upd_valid(valid_a), .upd_ready(rdy_a),
    .x_old(x_old), .x_new(x_new), .busy(busy_a), .done(done_a), .converged(conv_a),
    .max_iter_hit(maxh_a), .iter_count(iter_a), .conv_mask(mask_a)
  );

  gd_conv_controller #(.N_DIM(N), .MAX_ITER(2), .STABLE_CNT(2)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .upd_valid(valid_b), .upd_ready(rdy_b),
    .x_old(x_old), .x_new(x_new), .busy(busy_b), .done(done_b), .converged(conv_b),
    .max_iter_hit(maxh_b), .iter_count(iter_b), .conv_mask(mask_b)
  );

  typedef struct {
    logic [N-1:0] mask;
    logic [15:0]  iter;
    logic         conv;
    logic         maxh;
    logic         fin;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic rdy_of(input int sel);
    return (sel == 0) ? rdy_a : rdy_b;
  endfunction

  function automatic logic done_of(input int sel);
    return (sel == 0) ? done_a : done_b;
  endfunction

  function automatic logic [32*N-1:0] vec(input logic [31:0] d0, input logic [31:0] d1,
                                          input logic [31:0] d2, input logic [31:0] d3);
    return {d3, d2, d1, d0};
  endfunction

  // Monitor: an iteration result is presented when upd_ready re-rises during a
  // run or when done pulses; compare it against the oldest queued expectation.
  task automatic mon(input int sel, input logic rdy, input logic rdy_p, input logic busy_p,
                     input logic dn, input logic [N-1:0] mask, input logic [15:0] it,
                     input logic cv, input logic mh);
    exp_t  e;
    string tag;
    logic  empty;
    tag   = (sel == 0) ? "a" : "b";
    empty = (sel == 0) ? (q_a.size() == 0) : (q_b.size() == 0);
    if (dn || (rdy && !rdy_p && busy_p)) begin
      if (empty) begin
        n_total++;
        $display("FAIL %s_unexpected_output: done=%0b iter=%0d with nothing expected", tag, dn, it);
      end else begin
        if (sel == 0) e = q_a.pop_front();
        else          e = q_b.pop_front();
        check({tag, "_conv_mask"},    32'(mask), 32'(e.mask));
        check({tag, "_iter_count"},   32'(it),   32'(e.iter));
        check({tag, "_converged"},    32'(cv),   32'(e.conv));
        check({tag, "_max_iter_hit"}, 32'(mh),   32'(e.maxh));
        check({tag, "_done"},         32'(dn),   32'(e.fin));
      end
    end
  endtask

  logic rdy_p_a = 1'b0, busy_p_a = 1'b0, rdy_p_b = 1'b0, busy_p_b = 1'b0;

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    mon(0, rdy_a, rdy_p_a, busy_p_a, done_a, mask_a, iter_a, conv_a, maxh_a);
    mon(1, rdy_b, rdy_p_b, busy_p_b, done_b, mask_b, iter_b, conv_b, maxh_b);
    rdy_p_a  = rdy_a;
    busy_p_a = busy_a;
    rdy_p_b  = rdy_b;
    busy_p_b = busy_b;
  end

  task automatic start_run(input int sel);
    @(negedge clk);
    if (sel == 0) start_a = 1'b1;
    else          start_b = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    check("start_busy",  32'((sel == 0) ? busy_a : busy_b), 32'd1);
    check("start_iter",  32'((sel == 0) ? iter_a : iter_b), 32'd0);
    check("start_conv",  32'((sel == 0) ? conv_a : conv_b), 32'd0);
    check("start_maxh",  32'((sel == 0) ? maxh_a : maxh_b), 32'd0);
    check("start_mask",  32'((sel == 0) ? mask_a : mask_b), 32'd0);
  endtask

  task automatic send_upd(input int sel, input logic [32*N-1:0] o, input logic [32*N-1:0] n,
                          input logic [N-1:0] emask, input int eiter,
                          input logic econv, input logic emaxh);
    exp_t e;
    int   w;
    int   lat;
    e.mask = emask;
    e.iter = 16'(eiter);
    e.conv = econv;
    e.maxh = emaxh;
    e.fin  = econv | emaxh;
    if (sel == 0) q_a.push_back(e);
    else          q_b.push_back(e);
    x_old = o;
    x_new = n;
    w = 0;
    @(negedge clk);
    while (!rdy_of(sel) && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!rdy_of(sel)) begin
      n_total++;
      $display("FAIL upd_ready_timeout: upd_ready=0 after %0d cycles, expected 1", w);
      return;
    end
    if (sel == 0) valid_a = 1'b1;
    else          valid_b = 1'b1;
    @(posedge clk);
    #1;
    valid_a = 1'b0;
    valid_b = 1'b0;
    x_old = ~o;
    x_new = o;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!(rdy_of(sel) || done_of(sel)) && lat < 20);
    check("upd_ready_low_cycles", 32'(lat), 32'(N + 1));
  endtask

  task automatic check_idle_a(input string tag);
    check({tag, "_rdy"},  32'(rdy_a),  32'd0);
    check({tag, "_busy"}, 32'(busy_a), 32'd0);
    check({tag, "_done"}, 32'(done_a), 32'd0);
    check({tag, "_conv"}, 32'(conv_a), 32'd0);
    check({tag, "_maxh"}, 32'(maxh_a), 32'd0);
    check({tag, "_iter"}, 32'(iter_a), 32'd0);
    check({tag, "_mask"}, 32'(mask_a), 32'd0);
  endtask

  logic [32*N-1:0] old1, plus5, edge16, wrap_o, wrap_n, mix;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    old1   = vec(32'h0000_1000, 32'h0000_2000, 32'hFFFF_F000, 32'h0012_3400);
    plus5  = vec(32'h0000_1005, 32'h0000_2005, 32'hFFFF_F005, 32'h0012_3405);
    edge16 = vec(32'h0000_1000, 32'h0000_2000, 32'hFFFF_F010, 32'h0012_33F0);
    wrap_o = vec(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    wrap_n = vec(32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000);
    mix    = vec(32'h0000_100F, 32'h0000_1FF1, 32'hFFFF_F000, 32'h0012_3410);

    rst = 1'b1;
    start_a = 1'b0; start_b = 1'b0; valid_a = 1'b0; valid_b = 1'b0;
    x_old = '0; x_new = '0;
    #1;
    check_idle_a("reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Run 1: +5 LSB everywhere, converges after two iterations.
    start_run(0);
    send_upd(0, old1, plus5, 4'b1111, 1, 1'b0, 1'b0);
    send_upd(0, old1, plus5, 4'b1111, 2, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    check("run1_hold_conv", 32'(conv_a), 32'd1);
    check("run1_hold_iter", 32'(iter_a), 32'd2);
    check("run1_busy_off",  32'(busy_a), 32'd0);
    check("run1_done_off",  32'(done_a), 32'd0);

    // Run 2: +/-16 edges miss, wrap-around converges, then limit of 3 is hit.
    start_run(0);
    send_upd(0, old1, edge16, 4'b0011, 1, 1'b0, 1'b0);
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    check("busy_start_ignored_iter", 32'(iter_a), 32'd1);
    check("busy_start_ignored_busy", 32'(busy_a), 32'd1);
    send_upd(0, wrap_o, wrap_n, 4'b1111, 2, 1'b0, 1'b0);
    send_upd(0, old1, mix, 4'b0111, 3, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    check("run2_hold_maxh", 32'(maxh_a), 32'd1);
    check("run2_hold_conv", 32'(conv_a), 32'd0);
    check("run2_hold_iter", 32'(iter_a), 32'd3);

    // Run 3: reset during CHECK of the second iteration.
    start_run(0);
    send_upd(0, old1, plus5, 4'b1111, 1, 1'b0, 1'b0);
    x_old = old1;
    x_new = plus5;
    @(negedge clk);
    valid_a = 1'b1;
    @(posedge clk);
    #1;
    valid_a = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_idle_a("midrun_reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("after_reset_idle_busy", 32'(busy_a), 32'd0);

    // Run 4: fresh start after reset behaves normally.
    start_run(0);
    send_upd(0, old1, plus5, 4'b1111, 1, 1'b0, 1'b0);
    send_upd(0, old1, plus5, 4'b1111, 2, 1'b1, 1'b0);

    // Instance b: limit equals stable count, convergence wins the tie.
    start_run(1);
    send_upd(1, old1, plus5, 4'b1111, 1, 1'b0, 1'b0);
    send_upd(1, old1, plus5, 4'b1111, 2, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    check("tie_conv", 32'(conv_b), 32'd1);
    check("tie_maxh", 32'(maxh_b), 32'd0);

    check("queue_a_drained", 32'(q_a.size()), 32'd0);
    check("queue_b_drained", 32'(q_b.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
